// File: rtl/nexys_starship_spawn_sched_pkg.sv
// Shared definitions for the starship spawn scheduler: side indices, FSM encoding
// and a small popcount helper.
package nexys_starship_spawn_sched_pkg;

  localparam int NUM_SIDES  = 4;
  localparam int SIDE_TOP   = 0;
  localparam int SIDE_BTM   = 1;
  localparam int SIDE_LEFT  = 2;
  localparam int SIDE_RIGHT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PICK  = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  function automatic logic [2:0] popcount4(input logic [NUM_SIDES-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NUM_SIDES; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/nexys_starship_rr_pick4.sv
// Combinational 4-way round-robin picker: first set bit of cand searching
// ptr, ptr+1, ... modulo 4.
module nexys_starship_rr_pick4
  import nexys_starship_spawn_sched_pkg::*;
(
  input  logic [NUM_SIDES-1:0] cand,
  input  logic [1:0]           ptr,
  output logic [1:0]           sel,
  output logic                 valid
);

  logic [1:0] idx;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_SIDES - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (cand[idx]) begin
        sel   = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nexys_starship_spawn_sched.sv
// Monster spawn scheduler: paces spawn attempts, caps concurrent monsters by level
// and issues one-cycle one-hot spawn pulses to the four side state machines.
module nexys_starship_spawn_sched
  import nexys_starship_spawn_sched_pkg::*;
#(
  parameter int INIT_INTERVAL    = 8,
  parameter int MIN_INTERVAL     = 2,
  parameter int INTERVAL_STEP    = 1,
  parameter int SPAWNS_PER_LEVEL = 4,
  parameter int MAX_LEVEL        = 3,
  parameter int CNT_W            = 5
) (
  input  logic                 board_clk,
  input  logic                 Reset,
  input  logic                 tick,
  input  logic                 play_flag,
  input  logic                 gameover_ctrl,
  input  logic [NUM_SIDES-1:0] rand_req,
  input  logic [NUM_SIDES-1:0] side_busy,
  output logic [NUM_SIDES-1:0] spawn,
  output logic [1:0]           level,
  output logic [7:0]           spawn_total,
  output logic                 q_Idle,
  output logic                 q_Wait,
  output logic                 q_Pick,
  output logic                 q_Issue
);

  localparam int LC_W = $clog2(SPAWNS_PER_LEVEL + 1);
  localparam logic signed [CNT_W+2:0] INIT_S = (CNT_W+3)'(INIT_INTERVAL);
  localparam logic signed [CNT_W+2:0] MIN_S  = (CNT_W+3)'(MIN_INTERVAL);
  localparam logic signed [CNT_W+2:0] STEP_S = (CNT_W+3)'(INTERVAL_STEP);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [1:0]           level_n, rr_ptr, rr_n, sel_q, sel_n;
  logic [7:0]           total_n;
  logic [LC_W-1:0]      lvl_cnt, lc_n, lc_inc;
  logic [NUM_SIDES-1:0] spawn_n, cand;
  logic [1:0]           pick_sel, lvl_new;
  logic                 pick_valid, abort;
  logic [2:0]           active, max_active;

  // Attempt interval for a given level, floored at MIN_INTERVAL.
  function automatic logic [CNT_W-1:0] reload_for(input logic [1:0] lvl);
    logic signed [CNT_W+2:0] r;
    r = INIT_S - ($signed({{(CNT_W+1){1'b0}}, lvl}) * STEP_S);
    if (r < MIN_S) r = MIN_S;
    return r[CNT_W-1:0];
  endfunction

  assign cand       = rand_req & ~side_busy;
  assign active     = popcount4(side_busy);
  assign max_active = {1'b0, level} + 3'd1;
  assign abort      = gameover_ctrl | ~play_flag;

  nexys_starship_rr_pick4 u_pick (
    .cand  (cand),
    .ptr   (rr_ptr),
    .sel   (pick_sel),
    .valid (pick_valid)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    total_n = spawn_total;
    rr_n    = rr_ptr;
    lc_n    = lvl_cnt;
    sel_n   = sel_q;
    spawn_n = '0;
    lc_inc  = lvl_cnt + LC_W'(1);
    lvl_new = level;
    unique case (state)
      ST_IDLE: begin
        if (!abort) begin
          state_n = ST_WAIT;
          cnt_n   = CNT_W'(INIT_INTERVAL);
          level_n = '0;
          total_n = '0;
          rr_n    = '0;
          lc_n    = '0;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (tick) begin
          cnt_n = (cnt == '0) ? '0 : cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state_n = ST_PICK;
        end
      end
      ST_PICK: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (!pick_valid || active >= max_active) begin
          cnt_n   = reload_for(level);
          state_n = ST_WAIT;
        end else begin
          spawn_n = NUM_SIDES'(1) << pick_sel;
          sel_n   = pick_sel;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The pulse is on the wire this cycle, so it is accounted for even on abort.
        rr_n    = sel_q + 2'd1;
        total_n = (spawn_total == 8'hFF) ? spawn_total : spawn_total + 8'd1;
        if (lc_inc == LC_W'(SPAWNS_PER_LEVEL)) begin
          lc_n    = '0;
          lvl_new = (level >= 2'(MAX_LEVEL)) ? level : level + 2'd1;
        end else begin
          lc_n = lc_inc;
        end
        level_n = lvl_new;
        cnt_n   = reload_for(lvl_new);
        state_n = abort ? ST_IDLE : ST_WAIT;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      cnt         <= '0;
      level       <= '0;
      spawn_total <= '0;
      rr_ptr      <= '0;
      lvl_cnt     <= '0;
      sel_q       <= '0;
      spawn       <= '0;
    end else begin
      cnt         <= cnt_n;
      level       <= level_n;
      spawn_total <= total_n;
      rr_ptr      <= rr_n;
      lvl_cnt     <= lc_n;
      sel_q       <= sel_n;
      spawn       <= spawn_n;
    end
  end

  assign q_Idle  = (state == ST_IDLE);
  assign q_Wait  = (state == ST_WAIT);
  assign q_Pick  = (state == ST_PICK);
  assign q_Issue = (state == ST_ISSUE);

endmodule
